alu_seq_bcd: RTL
================

// Module: alu_seq_bcd
// PURPOSE
//  Registered, handshaked 6502-class ALU. Generalised to WIDTH bits, with optional decimal (BCD) ADC/SBC.
//  Sits between decode/regfile and writeback. Accepts one op per handshake and returns the result with N/V/Z/C.
//  Binary ops take 1 cycle. Decimal ADC/SBC take 2 cycles (extra nibble-adjust state).
// PARAMETERS
//  WIDTH      8  operand/result width; must be a multiple of 4 and >= 4
//  DECIMAL_EN 1  1: dec_mode honoured on ADC/SBC; 0: dec_mode ignored (binary only)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous active-high reset
//  in_valid   in   1      op/operands valid
//  in_ready   out  1      block can accept an op this cycle
//  op         in   4      0 ADC, 1 SBC, 2 AND, 3 ORA, 4 EOR, 5 ASL, 6 LSR, 7 ROL, 8 ROR, 9 CMP; 10-15 PASS
//  a          in   WIDTH  operand A (accumulator side)
//  b          in   WIDTH  operand B (memory side; ignored by shifts/PASS)
//  carry_in   in   1      C flag in
//  dec_mode   in   1      D flag in
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  registered result
//  flag_n/v/z/c out 1 each  registered flags
//  flag_v_upd out  1      1 if op defines V (ADC, SBC only)
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; out_valid=0; result=0; all flags=0; flag_v_upd=0. in_ready=1 once reset deasserts.
//  FSM states: IDLE, DADJ, HOLD.
//   IDLE: in_ready=1. On in_valid, capture the op and compute the binary result.
//     Decimal ADC/SBC (DECIMAL_EN & dec_mode): go to DADJ.
//     All other ops: go to HOLD with out_valid=1 the next cycle.
//   DADJ: apply the nibble adjust, then go to HOLD; out_valid=1 the cycle after.
//   HOLD: out_valid=1. result and flags are stable until out_ready=1.
//     in_ready = out_ready; an accept in HOLD behaves exactly as an accept in IDLE.
//     out_ready=1 & in_valid=0 -> IDLE.
//  Throughput: 1 op/cycle for binary ops when out_ready is held high.
//  Binary arithmetic: internal WIDTH+1 bits.
//   ADC: a+b+carry_in. SBC: a+~b+carry_in.
//   C = bit WIDTH. V = (a[MSB]==b'[MSB]) & (r[MSB]!=a[MSB]), where b' is b for ADC and ~b for SBC.
//  CMP: a+~b+1; C/N/Z updated; V not updated (flag_v_upd=0, flag_v=0); carry_in ignored; result=a-b.
//  Logic ops (AND/ORA/EOR): C = carry_in passes through.
//  Shifts:
//   ASL: C=a[MSB], r={a[MSB-1:0],0}.  LSR: C=a[0], r={0,a[MSB:1]}.
//   ROL: r={a[MSB-1:0],carry_in}.     ROR: r={carry_in,a[MSB:1]}.
//  PASS: r=a; C=carry_in; V=0.
//  Decimal adjust, per nibble from LSB with a digit-carry chain:
//   ADC: if nibble>9 or nibble carry-out, add 6 and propagate. C = final decimal carry.
//   SBC: if nibble borrowed, subtract 6. C = NOT final borrow.
//  Decimal flags: N and Z from the adjusted result; V from the binary stage.
//  Non-BCD inputs: apply the same rule mechanically. The result is deterministic; no error is flagged.
//  N = r[MSB] and Z = (r==0) for every op.
//  Inputs are sampled only on the accept edge; later changes to a/b/op do not affect the in-flight op.
//  Reset in DADJ or HOLD: the in-flight result is discarded and out_valid drops immediately.
//  out_valid never drops without out_ready, except on reset.
// TESTING
//  1 ADC a=0x50 b=0x50 cin=0 d=0 -> next cycle: result=0xA0, N=1 V=1 Z=0 C=0.
//  2 ADC decimal a=0x58 b=0x46 cin=1 d=1 -> out_valid 2 cycles after accept: result=0x05, C=1 Z=0 N=0.
//  3 SBC a=0x00 b=0x01 cin=1 d=0 -> result=0xFF, C=0 N=1 V=0.
//    SBC decimal a=0x10 b=0x01 cin=1 d=1 -> result=0x09, C=1.
//  4 ROR a=0x01 cin=1 -> result=0x80, C=1 N=1.
//    ASL a=0x80 -> result=0x00, C=1 Z=1.
//    CMP a=0x10 b=0x10 -> Z=1 C=1, flag_v_upd=0.
//  5 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> result/flags stable, in_ready=0.
//    Release -> next op accepted the same cycle; back-to-back EORs give 1 result/cycle.
//  6 Assert rst while in DADJ -> out_valid=0 and result=0 immediately.
//    After release, a new ADC 0x01+0x01 -> result=0x02.
//    Repeat tests 1-3 with WIDTH=16, DECIMAL_EN=0: dec_mode ignored.

Source files
------------

// File: rtl/alu_seq_bcd_if.sv
// rtl/alu_seq_bcd_if.sv - op/result handshake bundle for the sequential BCD-capable ALU
interface alu_seq_bcd_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             dec_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_n;
    logic             flag_v;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v_upd;

    modport master (
        output in_valid, op, a, b, carry_in, dec_mode, out_ready,
        input  in_ready, out_valid, result, flag_n, flag_v, flag_z, flag_c, flag_v_upd
    );

    modport slave (
        input  in_valid, op, a, b, carry_in, dec_mode, out_ready,
        output in_ready, out_valid, result, flag_n, flag_v, flag_z, flag_c, flag_v_upd
    );
endinterface

// File: rtl/alu_seq_bcd.sv
// rtl/alu_seq_bcd.sv - registered handshaked 6502-class ALU with optional decimal ADC/SBC
module alu_seq_bcd #(
    parameter int WIDTH      = 8,
    parameter bit DECIMAL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    alu_seq_bcd_if.slave bus
);
    localparam int MSB     = WIDTH - 1;
    localparam int NIBBLES = WIDTH / 4;

    localparam logic [3:0] OP_ADC = 4'd0;
    localparam logic [3:0] OP_SBC = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_ORA = 4'd3;
    localparam logic [3:0] OP_EOR = 4'd4;
    localparam logic [3:0] OP_ASL = 4'd5;
    localparam logic [3:0] OP_LSR = 4'd6;
    localparam logic [3:0] OP_ROL = 4'd7;
    localparam logic [3:0] OP_ROR = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;

    typedef enum logic [1:0] {IDLE, DADJ, HOLD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             n_q, n_d, v_q, v_d, z_q, z_d, c_q, c_d;
    logic             vupd_q, vupd_d, cin_q, cin_d, sbc_q, sbc_d;

    logic [WIDTH-1:0] bx, bin_r, dec_r;
    logic [WIDTH:0]   sum;
    logic [4:0]       t;
    logic             cx, bin_c, bin_v, bin_vupd, dec_c, dc;
    logic             in_ready, accept, is_dec;

    always_comb begin
        bx       = (bus.op == OP_SBC || bus.op == OP_CMP) ? ~bus.b : bus.b;
        cx       = (bus.op == OP_CMP) ? 1'b1 : bus.carry_in;
        sum      = {1'b0, bus.a} + {1'b0, bx} + {{WIDTH{1'b0}}, cx};
        bin_r    = bus.a;
        bin_c    = bus.carry_in;
        bin_v    = 1'b0;
        bin_vupd = 1'b0;
        case (bus.op)
            OP_ADC, OP_SBC: begin
                bin_r    = sum[MSB:0];
                bin_c    = sum[WIDTH];
                bin_v    = (bus.a[MSB] == bx[MSB]) && (sum[MSB] != bus.a[MSB]);
                bin_vupd = 1'b1;
            end
            OP_CMP: begin
                bin_r = sum[MSB:0];
                bin_c = sum[WIDTH];
            end
            OP_AND: bin_r = bus.a & bus.b;
            OP_ORA: bin_r = bus.a | bus.b;
            OP_EOR: bin_r = bus.a ^ bus.b;
            OP_ASL: begin
                bin_r = {bus.a[MSB-1:0], 1'b0};
                bin_c = bus.a[MSB];
            end
            OP_LSR: begin
                bin_r = {1'b0, bus.a[MSB:1]};
                bin_c = bus.a[0];
            end
            OP_ROL: begin
                bin_r = {bus.a[MSB-1:0], bus.carry_in};
                bin_c = bus.a[MSB];
            end
            OP_ROR: begin
                bin_r = {bus.carry_in, bus.a[MSB:1]};
                bin_c = bus.a[0];
            end
            default: ;
        endcase
    end

    // Digit-serial decimal adjust from the captured operands; dc is carry for ADC, borrow for SBC.
    always_comb begin
        dc    = sbc_q ? ~cin_q : cin_q;
        dec_r = '0;
        t     = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (sbc_q) begin
                t  = {1'b0, opa_q[4*i +: 4]} - {1'b0, opb_q[4*i +: 4]} - {4'b0, dc};
                dc = t[4];
                dec_r[4*i +: 4] = t[4] ? t[3:0] - 4'd6 : t[3:0];
            end else begin
                t  = {1'b0, opa_q[4*i +: 4]} + {1'b0, opb_q[4*i +: 4]} + {4'b0, dc};
                dc = (t > 5'd9);
                dec_r[4*i +: 4] = dc ? t[3:0] + 4'd6 : t[3:0];
            end
        end
        dec_c = sbc_q ? ~dc : dc;
    end

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            HOLD:    in_ready = bus.out_ready;
            default: in_ready = 1'b0;
        endcase
        if (rst) begin
            in_ready = 1'b0;
        end
        accept = bus.in_valid && in_ready;
        is_dec = DECIMAL_EN && bus.dec_mode && (bus.op == OP_ADC || bus.op == OP_SBC);

        state_d  = state_q;
        result_d = result_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        n_d      = n_q;
        v_d      = v_q;
        z_d      = z_q;
        c_d      = c_q;
        vupd_d   = vupd_q;
        cin_d    = cin_q;
        sbc_d    = sbc_q;

        if (accept) begin
            opa_d    = bus.a;
            opb_d    = bus.b;
            cin_d    = bus.carry_in;
            sbc_d    = (bus.op == OP_SBC);
            result_d = bin_r;
            n_d      = bin_r[MSB];
            z_d      = (bin_r == '0);
            c_d      = bin_c;
            v_d      = bin_v;
            vupd_d   = bin_vupd;
            state_d  = is_dec ? DADJ : HOLD;
        end else begin
            case (state_q)
                DADJ: begin
                    result_d = dec_r;
                    n_d      = dec_r[MSB];
                    z_d      = (dec_r == '0);
                    c_d      = dec_c;
                    state_d  = HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            vupd_q   <= 1'b0;
            cin_q    <= 1'b0;
            sbc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            n_q      <= n_d;
            v_q      <= v_d;
            z_q      <= z_d;
            c_q      <= c_d;
            vupd_q   <= vupd_d;
            cin_q    <= cin_d;
            sbc_q    <= sbc_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = (state_q == HOLD);
    assign bus.result     = result_q;
    assign bus.flag_n     = n_q;
    assign bus.flag_v     = v_q;
    assign bus.flag_z     = z_q;
    assign bus.flag_c     = c_q;
    assign bus.flag_v_upd = vupd_q;
endmodule
